// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: steps a frequency word through num_steps values, each held dwell cycles.
// First step word and strobe appear one cycle after i_start is sampled; no backpressure, outputs are registered.
module nco_sweep_ctrl #(
    parameter int STEP_W  = 10,
    parameter int DWELL_W = 20
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_cont,
    input  logic [STEP_W-1:0]  i_start_step,
    input  logic [STEP_W-1:0]  i_step_inc,
    input  logic [3:0]         i_num_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [STEP_W-1:0]  o_freq_step,
    output logic [3:0]         o_step_idx,
    output logic               o_step_strobe,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [STEP_W-1:0]  freq_q;
    logic [STEP_W-1:0]  start_q;
    logic [STEP_W-1:0]  inc_q;
    logic [3:0]         idx_q;
    logic [3:0]         last_idx_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_last_q;
    logic               cont_q;
    logic               strobe_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         last_idx_d;
    logic [DWELL_W-1:0] dwell_last_d;
    logic               expiry;
    logic               last_step;

    // Config is latched as terminal values (count-1) so zero requests collapse to one.
    always_comb begin
        last_idx_d   = (i_num_steps == 4'd0) ? 4'd0 : i_num_steps - 4'd1;
        dwell_last_d = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
    end

    assign expiry    = (cnt_q == dwell_last_q);
    assign last_step = (idx_q == last_idx_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            freq_q       <= '0;
            start_q      <= '0;
            inc_q        <= '0;
            idx_q        <= '0;
            last_idx_q   <= '0;
            cnt_q        <= '0;
            dwell_last_q <= '0;
            cont_q       <= 1'b0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        start_q      <= i_start_step;
                        inc_q        <= i_step_inc;
                        last_idx_q   <= last_idx_d;
                        dwell_last_q <= dwell_last_d;
                        cont_q       <= i_cont;
                        freq_q       <= i_start_step;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        strobe_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= DWELL;
                    end
                end
                DWELL: begin
                    // Abort wins over expiry and leaves the tone where it is.
                    if (i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!expiry) begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end else if (!last_step) begin
                        freq_q   <= freq_q + inc_q;
                        idx_q    <= idx_q + 4'd1;
                        cnt_q    <= '0;
                        strobe_q <= 1'b1;
                    end else if (cont_q) begin
                        freq_q   <= start_q;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_freq_step   = freq_q;
    assign o_step_idx    = idx_q;
    assign o_step_strobe = strobe_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule
